// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// It keeps full throughput under back-pressure and uses FLUSH to insert a bubble.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] NOP_VALUE   = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] Din,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Dout,
  output logic [1:0]       OCC
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_DIN  = 2'b01,
    SEL_SKID = 2'b10,
    SEL_NOP  = 2'b11
  } dout_sel_t;

  state_t           state_p0, state_d;
  dout_sel_t        dout_sel;
  logic             skid_ld;
  logic             in_xfer, out_xfer;
  logic [WIDTH-1:0] dout_p0, skid_p0;

  // Handshake outputs come only from the state register, so OUT_READY never
  // reaches IN_READY combinationally.
  always_comb begin
    OUT_VALID = 1'b0;
    IN_READY  = 1'b0;
    OCC       = 2'd0;
    case (state_p0)
      EMPTY:   begin OUT_VALID = 1'b0; IN_READY = 1'b1; OCC = 2'd0; end
      HALF:    begin OUT_VALID = 1'b1; IN_READY = 1'b1; OCC = 2'd1; end
      FULL:    begin OUT_VALID = 1'b1; IN_READY = 1'b0; OCC = 2'd2; end
      default: begin OUT_VALID = 1'b0; IN_READY = 1'b0; OCC = 2'd0; end
    endcase
  end

  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = OUT_VALID & OUT_READY;

  always_comb begin
    state_d  = state_p0;
    dout_sel = SEL_HOLD;
    skid_ld  = 1'b0;
    if (FLUSH) begin
      state_d  = EMPTY;
      dout_sel = SEL_NOP;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_xfer) begin
            dout_sel = SEL_DIN;
            state_d  = HALF;
          end
        end
        HALF: begin
          if (in_xfer && out_xfer) begin
            dout_sel = SEL_DIN;
          end else if (in_xfer) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            dout_sel = SEL_SKID;
            state_d  = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stage p0: control state and payload registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_p0 <= EMPTY;
    else     state_p0 <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_p0 <= RESET_VALUE;
      skid_p0 <= RESET_VALUE;
    end else begin
      case (dout_sel)
        SEL_DIN:  dout_p0 <= Din;
        SEL_SKID: dout_p0 <= skid_p0;
        SEL_NOP:  dout_p0 <= NOP_VALUE;
        default:  dout_p0 <= dout_p0;
      endcase
      if (skid_ld) skid_p0 <= Din;
    end
  end

  assign Dout = dout_p0;

endmodule
